rgb_gray_feeder: RTL

Front-end stage that converts a streamed 24-bit RGB frame into 8-bit luminance and feeds it to the edge detector's `GrayImage_i` / `start_i` inputs. It absorbs a bursty, back-pressured RGB source in a small FIFO. Once enough pixels are buffered, it fires a one-cycle start pulse and then emits exactly IMG_X_SIZE*IMG_Y_SIZE gray pixels, one per clock, which is the contiguous stream the detector requires.

---
 rtl/rgb_gray_feeder_if.sv | 15 +
 rtl/rgb_gray_feeder.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rgb_gray_feeder_if.sv
// Stream bundle between an RGB source, the gray feeder and the edge detector.
// slave = feeder side, master = source/detector side.
interface rgb_gray_feeder_if;
  logic        rgb_valid_i;
  logic [23:0] Rgb_i;
  logic        rgb_ready_o;
  logic        edge_start_o;
  logic [7:0]  GrayImage_o;
  logic        gray_valid_o;

  modport slave  (input  rgb_valid_i, Rgb_i,
                  output rgb_ready_o, edge_start_o, GrayImage_o, gray_valid_o);
  modport master (output rgb_valid_i, Rgb_i,
                  input  rgb_ready_o, edge_start_o, GrayImage_o, gray_valid_o);
endinterface

// File: rtl/rgb_gray_feeder.sv
// RGB->luma front end: 2-stage convert, small FIFO, contiguous gray burst to the edge detector.
// Define GRAY_ROUND_EN to round half-up instead of truncating the luma shift.
module rgb_gray_feeder #(
  parameter int IMG_X_SIZE = 564,
  parameter int IMG_Y_SIZE = 1221,
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  rgb_gray_feeder_if.slave  bus,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              underrun_o
);
  localparam int TOTAL = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = AW + 1;
  localparam logic [CW-1:0] TOTAL_C   = CW'(TOTAL);
  localparam logic [FW-1:0] DEPTH_C   = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] PREFILL_C = FW'(PREFILL);
`ifdef GRAY_ROUND_EN
  localparam logic [15:0] RND = 16'd128;
`else
  localparam logic [15:0] RND = 16'd0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_STREAM, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic            ur_q, ur_d;
  logic [2:1]      vld_pipe_q;
  logic [15:0]     p_r_q, p_g_q, p_b_q;
  logic [7:0]      y_q, y_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FW-1:0]   cnt_q, inflight, occ;
  logic [7:0]      gray_q;
  logic            gv_q;
  logic            rdy, acc, push, pop, streaming;

  // Reserve FIFO room for pixels still in the converter so a push never overflows.
  assign inflight  = FW'(vld_pipe_q[1]) + FW'(vld_pipe_q[2]);
  assign occ       = cnt_q + inflight;
  assign streaming = (state_q == S_START) || (state_q == S_STREAM);
  assign rdy       = (state_q == S_FILL || streaming) && (in_cnt_q < TOTAL_C) && (occ < DEPTH_C);
  assign acc       = bus.rgb_valid_i && rdy;
  assign push      = vld_pipe_q[2];
  assign pop       = streaming && (cnt_q != '0) && (out_cnt_q < TOTAL_C);
  assign y_d       = 8'((p_r_q + p_g_q + p_b_q + RND) >> 8);

  assign bus.rgb_ready_o  = rdy;
  assign bus.edge_start_o = (state_q == S_START);
  assign bus.GrayImage_o  = gray_q;
  assign bus.gray_valid_o = gv_q;
  assign busy_o           = (state_q == S_FILL) || streaming;
  assign frame_done_o     = (state_q == S_DONE);
  assign underrun_o       = ur_q;

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ur_d      = ur_q;
    if (acc) in_cnt_d  = in_cnt_q + CW'(1);
    if (pop) out_cnt_d = out_cnt_q + CW'(1);
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d   = S_FILL;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        ur_d      = 1'b0;
      end
      S_FILL: if (cnt_q >= PREFILL_C || (in_cnt_q == TOTAL_C && vld_pipe_q == 2'b00))
        state_d = S_START;
      S_START:  state_d = S_STREAM;
      S_STREAM: if (out_cnt_q == TOTAL_C) state_d = S_DONE;
                else if (cnt_q == '0)     ur_d    = 1'b1;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ur_q       <= 1'b0;
      vld_pipe_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      gray_q     <= 8'h00;
      gv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      ur_q       <= ur_d;
      vld_pipe_q <= {vld_pipe_q[1], acc};
      gv_q       <= pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        gray_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + FW'(1);
        2'b01:   cnt_q <= cnt_q - FW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Datapath registers carry no reset; validity is tracked by vld_pipe_q.
  always_ff @(posedge clk_i) begin
    if (acc) begin
      p_r_q <= 16'(bus.Rgb_i[23:16]) * 16'd77;
      p_g_q <= 16'(bus.Rgb_i[15:8])  * 16'd150;
      p_b_q <= 16'(bus.Rgb_i[7:0])   * 16'd29;
    end
    if (vld_pipe_q[1]) y_q <= y_d;
    if (push) mem_q[wr_ptr_q] <= y_q;
  end
endmodule
